// File: rtl/axi_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_mem_arbiter
// Brief    : Single-outstanding AXI4 master arbiter for I-cache line fills and
//            D-cache fills / write-backs. Define ARB_DCACHE_PRIORITY_EN for
//            fixed D-cache priority; otherwise simultaneous requests alternate.
// Revision : 1.0 - initial release
// ============================================================================
module axi_mem_arbiter #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int LINE_BEATS = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  // I-cache
  input  logic                    i_ic_req_valid,
  input  logic [ADDR_WIDTH-1:0]   i_ic_req_addr,
  output logic                    o_ic_req_ready,
  output logic [DATA_WIDTH-1:0]   o_ic_rdata,
  output logic                    o_ic_rvalid,
  output logic                    o_ic_done,
  // D-cache
  input  logic                    i_dc_req_valid,
  input  logic                    i_dc_req_store,
  input  logic [ADDR_WIDTH-1:0]   i_dc_req_addr,
  output logic                    o_dc_req_ready,
  input  logic [DATA_WIDTH-1:0]   i_dc_wdata,
  output logic                    o_dc_wready,
  output logic [DATA_WIDTH-1:0]   o_dc_rdata,
  output logic                    o_dc_rvalid,
  output logic                    o_dc_done,
  // AXI read address
  output logic [ID_WIDTH-1:0]     o_m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   o_m_axi_araddr,
  output logic [7:0]              o_m_axi_arlen,
  output logic [2:0]              o_m_axi_arsize,
  output logic [1:0]              o_m_axi_arburst,
  output logic                    o_m_axi_arlock,
  output logic [3:0]              o_m_axi_arcache,
  output logic [2:0]              o_m_axi_arprot,
  output logic                    o_m_axi_arvalid,
  input  logic                    i_m_axi_arready,
  // AXI read data
  input  logic [ID_WIDTH-1:0]     i_m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   i_m_axi_rdata,
  input  logic [1:0]              i_m_axi_rresp,
  input  logic                    i_m_axi_rlast,
  input  logic                    i_m_axi_rvalid,
  output logic                    o_m_axi_rready,
  // AXI write address
  output logic [ID_WIDTH-1:0]     o_m_axi_awid,
  output logic [ADDR_WIDTH-1:0]   o_m_axi_awaddr,
  output logic [7:0]              o_m_axi_awlen,
  output logic [2:0]              o_m_axi_awsize,
  output logic [1:0]              o_m_axi_awburst,
  output logic                    o_m_axi_awlock,
  output logic [3:0]              o_m_axi_awcache,
  output logic [2:0]              o_m_axi_awprot,
  output logic                    o_m_axi_awvalid,
  input  logic                    i_m_axi_awready,
  // AXI write data
  output logic [DATA_WIDTH-1:0]   o_m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] o_m_axi_wstrb,
  output logic                    o_m_axi_wlast,
  output logic                    o_m_axi_wvalid,
  input  logic                    i_m_axi_wready,
  // AXI write response
  input  logic [ID_WIDTH-1:0]     i_m_axi_bid,
  input  logic [1:0]              i_m_axi_bresp,
  input  logic                    i_m_axi_bvalid,
  output logic                    o_m_axi_bready
);

  localparam int c_off_bits = $clog2(LINE_BEATS * DATA_WIDTH / 8);
  localparam int c_size_val = $clog2(DATA_WIDTH / 8);
  localparam int c_lb_w     = $clog2(LINE_BEATS);
  localparam int c_cnt_w    = (c_lb_w > 3) ? c_lb_w : 3;
  localparam logic [ADDR_WIDTH-1:0] c_line_mask =
      ~((ADDR_WIDTH'(1) << c_off_bits) - ADDR_WIDTH'(1));

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_AR    = 3'd1,
    S_RDATA = 3'd2,
    S_AW    = 3'd3,
    S_WDATA = 3'd4,
    S_BRESP = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                 r_owner_dc;
  logic                 r_ic_done;
  logic                 r_dc_done;
  logic [c_cnt_w-1:0]   r_beat;
  logic                 w_grant;
  logic                 w_pick_dc;
  logic                 w_beat_last;
  logic                 w_unused;

  assign w_unused = ^{i_m_axi_rid, i_m_axi_rresp, i_m_axi_bid, i_m_axi_bresp};

  // The done cycle is kept free of grants so back-to-back bursts get one idle gap.
  assign w_grant = !reset && (r_state == S_IDLE) && !r_ic_done && !r_dc_done &&
                   (i_ic_req_valid || i_dc_req_valid);

`ifdef ARB_DCACHE_PRIORITY_EN
  assign w_pick_dc = i_dc_req_valid;
`else
  logic r_ic_turn;  // 0 after reset so the D-cache wins the first tie
  assign w_pick_dc = i_dc_req_valid && (!i_ic_req_valid || !r_ic_turn);
  always_ff @(posedge clk) begin
    if (reset)        r_ic_turn <= 1'b0;
    else if (w_grant) r_ic_turn <= w_pick_dc;
  end
`endif

  assign o_ic_req_ready = w_grant && !w_pick_dc;
  assign o_dc_req_ready = w_grant &&  w_pick_dc;
  assign o_ic_done      = r_ic_done;
  assign o_dc_done      = r_dc_done;
  assign w_beat_last    = (r_beat == c_cnt_w'(LINE_BEATS - 1));

  assign o_m_axi_arid    = ID_WIDTH'(r_owner_dc);
  assign o_m_axi_arlen   = 8'(LINE_BEATS - 1);
  assign o_m_axi_arsize  = 3'(c_size_val);
  assign o_m_axi_arburst = 2'b01;
  assign o_m_axi_arlock  = 1'b0;
  assign o_m_axi_arcache = 4'd0;
  assign o_m_axi_arprot  = 3'd0;
  assign o_m_axi_awid    = ID_WIDTH'(1);
  assign o_m_axi_awlen   = 8'(LINE_BEATS - 1);
  assign o_m_axi_awsize  = 3'(c_size_val);
  assign o_m_axi_awburst = 2'b01;
  assign o_m_axi_awlock  = 1'b0;
  assign o_m_axi_awcache = 4'd0;
  assign o_m_axi_awprot  = 3'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_owner_dc <= 1'b0;
      r_ic_done  <= 1'b0;
      r_dc_done  <= 1'b0;
      r_beat     <= '0;
    end else begin
      r_state   <= w_next;
      r_ic_done <= (r_state == S_RDATA) && i_m_axi_rvalid && i_m_axi_rlast && !r_owner_dc;
      r_dc_done <= ((r_state == S_RDATA) && i_m_axi_rvalid && i_m_axi_rlast && r_owner_dc) ||
                   ((r_state == S_BRESP) && i_m_axi_bvalid);
      if (w_grant) begin
        r_addr     <= (w_pick_dc ? i_dc_req_addr : i_ic_req_addr) & c_line_mask;
        r_owner_dc <= w_pick_dc;
      end
      if ((r_state == S_WDATA) && i_m_axi_wready)
        r_beat <= w_beat_last ? '0 : r_beat + c_cnt_w'(1);
    end
  end

  // Every channel output is gated by reset so the bus goes quiet immediately.
  always_comb begin
    w_next          = r_state;
    o_m_axi_arvalid = 1'b0;
    o_m_axi_araddr  = '0;
    o_m_axi_rready  = 1'b0;
    o_m_axi_awvalid = 1'b0;
    o_m_axi_awaddr  = '0;
    o_m_axi_wvalid  = 1'b0;
    o_m_axi_wdata   = '0;
    o_m_axi_wstrb   = '0;
    o_m_axi_wlast   = 1'b0;
    o_m_axi_bready  = 1'b0;
    o_dc_wready     = 1'b0;
    o_ic_rvalid     = 1'b0;
    o_ic_rdata      = '0;
    o_dc_rvalid     = 1'b0;
    o_dc_rdata      = '0;
    if (!reset) begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) w_next = (w_pick_dc && i_dc_req_store) ? S_AW : S_AR;
        end
        S_AR: begin
          o_m_axi_arvalid = 1'b1;
          o_m_axi_araddr  = r_addr;
          if (i_m_axi_arready) w_next = S_RDATA;
        end
        S_RDATA: begin
          o_m_axi_rready = 1'b1;
          if (i_m_axi_rvalid) begin
            if (r_owner_dc) begin
              o_dc_rvalid = 1'b1;
              o_dc_rdata  = i_m_axi_rdata;
            end else begin
              o_ic_rvalid = 1'b1;
              o_ic_rdata  = i_m_axi_rdata;
            end
            if (i_m_axi_rlast) w_next = S_IDLE;
          end
        end
        S_AW: begin
          o_m_axi_awvalid = 1'b1;
          o_m_axi_awaddr  = r_addr;
          if (i_m_axi_awready) w_next = S_WDATA;
        end
        S_WDATA: begin
          o_m_axi_wvalid = 1'b1;
          o_m_axi_wdata  = i_dc_wdata;
          o_m_axi_wstrb  = '1;
          o_m_axi_wlast  = w_beat_last;
          o_dc_wready    = i_m_axi_wready;
          if (i_m_axi_wready && w_beat_last) w_next = S_BRESP;
        end
        S_BRESP: begin
          o_m_axi_bready = 1'b1;
          if (i_m_axi_bvalid) w_next = S_IDLE;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_mem_arbiter.sv
`default_nettype none
// Testbench for axi_mem_arbiter: directed and randomized cache traffic checked
// against a rule-level model of arbitration, line alignment and burst framing.
module tb_axi_mem_arbiter;
  localparam int IDW = 13;
  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int LB  = 8;
`ifdef ARB_DCACHE_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic ic_req_valid, ic_req_ready, ic_rvalid, ic_done;
  logic [AW-1:0] ic_req_addr;
  logic [DW-1:0] ic_rdata;
  logic dc_req_valid, dc_req_store, dc_req_ready, dc_wready, dc_rvalid, dc_done;
  logic [AW-1:0] dc_req_addr;
  logic [DW-1:0] dc_wdata, dc_rdata;
  logic [IDW-1:0] arid, awid, rid, bid;
  logic [AW-1:0] araddr, awaddr;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, awsize, arprot, awprot;
  logic [1:0] arburst, awburst, rresp, bresp;
  logic [3:0] arcache, awcache;
  logic arlock, awlock, arvalid, arready, rlast, rvalid, rready;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [DW-1:0] rdata, wdata;
  logic [DW/8-1:0] wstrb;

  int total = 0;
  int bad   = 0;
  bit last_dc = 1'b0;  // model: which requester was granted most recently

  always #5 clk = ~clk;

  axi_mem_arbiter #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_BEATS(LB)) dut (
    .clk(clk), .reset(reset),
    .i_ic_req_valid(ic_req_valid), .i_ic_req_addr(ic_req_addr), .o_ic_req_ready(ic_req_ready),
    .o_ic_rdata(ic_rdata), .o_ic_rvalid(ic_rvalid), .o_ic_done(ic_done),
    .i_dc_req_valid(dc_req_valid), .i_dc_req_store(dc_req_store), .i_dc_req_addr(dc_req_addr),
    .o_dc_req_ready(dc_req_ready), .i_dc_wdata(dc_wdata), .o_dc_wready(dc_wready),
    .o_dc_rdata(dc_rdata), .o_dc_rvalid(dc_rvalid), .o_dc_done(dc_done),
    .o_m_axi_arid(arid), .o_m_axi_araddr(araddr), .o_m_axi_arlen(arlen), .o_m_axi_arsize(arsize),
    .o_m_axi_arburst(arburst), .o_m_axi_arlock(arlock), .o_m_axi_arcache(arcache),
    .o_m_axi_arprot(arprot), .o_m_axi_arvalid(arvalid), .i_m_axi_arready(arready),
    .i_m_axi_rid(rid), .i_m_axi_rdata(rdata), .i_m_axi_rresp(rresp), .i_m_axi_rlast(rlast),
    .i_m_axi_rvalid(rvalid), .o_m_axi_rready(rready),
    .o_m_axi_awid(awid), .o_m_axi_awaddr(awaddr), .o_m_axi_awlen(awlen), .o_m_axi_awsize(awsize),
    .o_m_axi_awburst(awburst), .o_m_axi_awlock(awlock), .o_m_axi_awcache(awcache),
    .o_m_axi_awprot(awprot), .o_m_axi_awvalid(awvalid), .i_m_axi_awready(awready),
    .o_m_axi_wdata(wdata), .o_m_axi_wstrb(wstrb), .o_m_axi_wlast(wlast), .o_m_axi_wvalid(wvalid),
    .i_m_axi_wready(wready),
    .i_m_axi_bid(bid), .i_m_axi_bresp(bresp), .i_m_axi_bvalid(bvalid), .o_m_axi_bready(bready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ctl"}, 64'({arvalid, awvalid, wvalid, wlast, rready, bready, ic_req_ready,
                            dc_req_ready, ic_rvalid, dc_rvalid, ic_done, dc_done, dc_wready}), 64'd0);
    chk({tag, "_addr"}, araddr | awaddr, 64'd0);
    chk({tag, "_data"}, ic_rdata | dc_rdata | wdata, 64'd0);
  endtask

  function automatic logic [63:0] line_of(input logic [63:0] a);
    return a - (a % 64);  // 8 beats x 8 bytes per line
  endfunction

  task automatic grant(input bit ic_v, input bit dc_v, input logic [63:0] ia,
                       input logic [63:0] da, input bit st, output bit won_dc);
    bit exp_dc;
    int n;
    ic_req_valid = ic_v; ic_req_addr = ia;
    dc_req_valid = dc_v; dc_req_addr = da; dc_req_store = st;
    #1;
    n = 0;
    while (!(ic_req_ready || dc_req_ready) && n < 8) begin
      chk("ready_excl", 64'(ic_req_ready & dc_req_ready), 64'd0);
      tick(); #1; n++;
    end
    chk("grant_seen", 64'(ic_req_ready | dc_req_ready), 64'd1);
    chk("ready_excl", 64'(ic_req_ready & dc_req_ready), 64'd0);
    exp_dc = dc_v && (!ic_v || PRIO || !last_dc);
    chk("grant_dc", 64'(dc_req_ready), 64'(exp_dc));
    chk("grant_ic", 64'(ic_req_ready), 64'(!exp_dc));
    won_dc = exp_dc;
    last_dc = exp_dc;
    tick();
    if (exp_dc) dc_req_valid = 1'b0; else ic_req_valid = 1'b0;
  endtask

  task automatic serve_read(input bit own_dc, input logic [63:0] addr, input int dly,
                            input int rst_after);
    logic [63:0] d;
    int beats, cyc;
    for (int c = 0; c <= dly; c++) begin
      arready = (c == dly); rvalid = 1'b1; rlast = 1'b0; rdata = {$urandom, $urandom};
      #1;
      chk("ar_valid", 64'(arvalid), 64'd1);
      chk("ar_addr", araddr, line_of(addr));
      chk("ar_fields", {arlen, 1'b0, arsize, 2'b0, arburst, 3'b0, arlock, arcache, 1'b0, arprot},
          {8'd7, 1'b0, 3'd3, 2'b0, 2'b01, 3'b0, 1'b0, 4'd0, 1'b0, 3'd0});
      chk("ar_id", 64'(arid), 64'(own_dc));
      chk("ar_nofwd", 64'({rready, ic_rvalid, dc_rvalid}), 64'd0);
      tick();
    end
    arready = 1'b0;
    beats = 0; cyc = 0;
    while (beats < LB && cyc < 40) begin
      if (rst_after != 0 && beats == rst_after) begin
        reset = 1'b1; rvalid = 1'b1; rlast = 1'b0;
        #1;
        chk_quiet("rst_mid");
        tick();
        reset = 1'b0; last_dc = 1'b0;
        for (int k = 0; k < 3; k++) begin
          rvalid = 1'b1; rlast = 1'b1; rdata = {$urandom, $urandom};
          #1;
          chk_quiet("post_rst");
          tick();
        end
        rvalid = 1'b0; rlast = 1'b0;
        return;
      end
      rvalid = ($urandom_range(0, 3) != 0);
      d = {$urandom, $urandom}; rdata = d;
      rlast = rvalid && (beats == LB - 1);
      rresp = 2'($urandom);
      #1;
      chk("r_ready", 64'(rready), 64'd1);
      chk("r_own_valid", 64'(own_dc ? dc_rvalid : ic_rvalid), 64'(rvalid));
      chk("r_other_valid", 64'(own_dc ? ic_rvalid : dc_rvalid), 64'd0);
      if (rvalid) chk("r_data", own_dc ? dc_rdata : ic_rdata, d);
      chk("r_early_done", 64'({ic_done, dc_done}), 64'd0);
      if (rvalid) beats++;
      cyc++;
      tick();
    end
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    chk("rd_done", 64'({ic_done, dc_done}), own_dc ? 64'd1 : 64'd2);
    chk("rd_done_idle", 64'({arvalid, rready, ic_req_ready, dc_req_ready}), 64'd0);
    tick();
    #1;
    chk("rd_done_pulse", 64'({ic_done, dc_done}), 64'd0);
  endtask

  task automatic serve_write(input logic [63:0] addr, input int dly, input bit tog, input bit poke);
    logic [63:0] d;
    int beats, cyc;
    for (int c = 0; c <= dly; c++) begin
      awready = (c == dly);
      #1;
      chk("aw_valid", 64'(awvalid), 64'd1);
      chk("aw_addr", awaddr, line_of(addr));
      chk("aw_fields", {awlen, 1'b0, awsize, 2'b0, awburst, 3'b0, awlock, awcache, 1'b0, awprot},
          {8'd7, 1'b0, 3'd3, 2'b0, 2'b01, 3'b0, 1'b0, 4'd0, 1'b0, 3'd0});
      chk("aw_id", 64'(awid), 64'd1);
      chk("aw_nowdata", 64'({wvalid, dc_wready}), 64'd0);
      tick();
    end
    awready = 1'b0;
    beats = 0; cyc = 0;
    d = {$urandom, $urandom}; dc_wdata = d;
    while (beats < LB && cyc < 40) begin
      wready = tog ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      if (poke && cyc == 0) begin ic_req_valid = 1'b1; ic_req_addr = {$urandom, $urandom}; end
      if (poke && cyc == 2) ic_req_valid = 1'b0;
      #1;
      chk("w_valid", 64'(wvalid), 64'd1);
      chk("w_data", wdata, d);
      chk("w_strb", 64'(wstrb), 64'hFF);
      chk("w_last", 64'(wlast), 64'(beats == LB - 1));
      chk("w_dcready", 64'(dc_wready), 64'(wready));
      chk("w_busy_ready", 64'({ic_req_ready, dc_req_ready, bready}), 64'd0);
      cyc++;
      if (wready) begin
        beats++;
        tick();
        d = {$urandom, $urandom}; dc_wdata = d;
      end else tick();
    end
    wready = 1'b0;
    cyc = $urandom_range(0, 3);
    for (int c = 0; c <= cyc; c++) begin
      bvalid = (c == cyc); bresp = 2'($urandom);
      #1;
      chk("b_ready", 64'(bready), 64'd1);
      chk("b_nodone", 64'({wvalid, dc_done}), 64'd0);
      tick();
    end
    bvalid = 1'b0;
    #1;
    chk("wr_done", 64'({ic_done, dc_done, bready}), 64'd2);
    tick();
    #1;
    chk("wr_done_pulse", 64'(dc_done), 64'd0);
  endtask

  task automatic run(input bit ic_v, input bit dc_v, input logic [63:0] ia, input logic [63:0] da,
                     input bit st, input int dly, input bit tog, input bit poke, input int rst_after);
    bit w;
    grant(ic_v, dc_v, ia, da, st, w);
    if (w && st) serve_write(da, dly, tog, poke);
    else         serve_read(w, w ? da : ia, dly, rst_after);
  endtask

  initial begin
    reset = 1'b1;
    ic_req_valid = 1'b1; ic_req_addr = 64'h1234; dc_req_valid = 1'b1; dc_req_store = 1'b0;
    dc_req_addr = 64'h5678; dc_wdata = '0;
    arready = 1'b1; awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
    rvalid = 1'b1; rlast = 1'b1; rdata = 64'hDEAD; rresp = 2'd0; rid = '0; bid = '0; bresp = 2'd0;
    for (int k = 0; k < 3; k++) begin
      tick(); #1;
      chk_quiet("reset");
    end
    ic_req_valid = 1'b0; dc_req_valid = 1'b0;
    arready = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; rvalid = 1'b0; rlast = 1'b0;
    reset = 1'b0;
    tick(); #1;
    chk_quiet("idle");

    // single I-cache fill, unaligned request address
    run(1'b1, 1'b0, 64'h1008, 64'h0, 1'b0, 0, 1'b0, 1'b0, 0);
    // simultaneous requests twice in a row, then whoever is still waiting
    run(1'b1, 1'b1, 64'h3010, 64'h4020, 1'b0, 1, 1'b0, 1'b0, 0);
    run(1'b1, 1'b1, 64'h3010, 64'h5000, 1'b1, 0, 1'b0, 1'b0, 0);
    run(ic_req_valid, dc_req_valid, 64'h3010, 64'h5000, 1'b1, 0, 1'b0, 1'b0, 0);
    // write-back with wready toggling every cycle
    run(1'b0, 1'b1, 64'h0, 64'h2040, 1'b1, 2, 1'b1, 1'b0, 0);
    // I-cache request withdrawn before it could be granted
    run(1'b0, 1'b1, 64'h0, {$urandom, $urandom}, 1'b1, 0, 1'b1, 1'b1, 0);
    for (int k = 0; k < 3; k++) begin
      #1; chk_quiet("dropped_req");
      tick();
    end
    // arready stalled for 5 cycles
    run(1'b0, 1'b1, 64'h0, {$urandom, $urandom}, 1'b0, 5, 1'b0, 1'b0, 0);
    // reset after beat 3 of a fill, then a tie (D-cache first) and a normal fill
    run(1'b1, 1'b0, {$urandom, $urandom}, 64'h0, 1'b0, 0, 1'b0, 1'b0, 3);
    run(1'b1, 1'b1, 64'h7788, 64'h9900, 1'b0, 0, 1'b0, 1'b0, 0);
    run(ic_req_valid, dc_req_valid, 64'h7788, 64'h9900, 1'b0, 0, 1'b0, 1'b0, 0);
    // randomized traffic
    for (int k = 0; k < 8; k++) begin
      bit iv, dv;
      iv = 1'($urandom_range(0, 1));
      dv = !iv || 1'($urandom_range(0, 1));
      run(iv, dv, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
          $urandom_range(0, 3), 1'b0, 1'b0, 0);
      ic_req_valid = 1'b0; dc_req_valid = 1'b0;
      #1;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_mem_arbiter.md
AXI_MEM_ARBITER -- requirements
Module: axi_mem_arbiter

Interface
REQ-001 Parameters SHALL be: ID_WIDTH, default 13, AXI ID width; ADDR_WIDTH, default 64, address width; DATA_WIDTH, default 64, beat width; LINE_BEATS, default 8, beats per cache line.
REQ-002 clk  in  1  clock; all logic on rising edge.
REQ-003 reset  in  1  reset, synchronous, active-high.
REQ-004 ic_req_valid  in  1  I-cache line-fill request, held until ic_req_ready.
REQ-005 ic_req_addr  in  ADDR_WIDTH  I-cache fill address.
REQ-006 ic_req_ready  out  1  I-cache request accepted; one-cycle pulse.
REQ-007 ic_rdata / ic_rvalid  out  DATA_WIDTH / 1  I-cache fill beat and its strobe.
REQ-008 ic_done  out  1  I-cache transaction complete; one-cycle pulse.
REQ-009 dc_req_valid / dc_req_store  in  1 / 1  D-cache request, held until dc_req_ready; store=1 selects line write-back, store=0 selects fill.
REQ-010 dc_req_addr  in  ADDR_WIDTH  D-cache line address.
REQ-011 dc_req_ready  out  1  D-cache request accepted; one-cycle pulse.
REQ-012 dc_wdata / dc_wready  in / out  DATA_WIDTH / 1  write-back beat; dc_wready high means the beat is consumed this cycle.
REQ-013 dc_rdata / dc_rvalid / dc_done  out  DATA_WIDTH / 1 / 1  fill beat, beat strobe, completion pulse.
REQ-014 m_axi_ar*, r*, aw*, w*, b*  mixed  per AXI4  master read and write channels; the ac* snoop channel is out of scope.

Function
REQ-015 FSM states SHALL be IDLE, AR, RDATA, AW, WDATA, BRESP; at most one transaction SHALL be outstanding at a time.
REQ-016 In IDLE with any request valid, the arbiter SHALL grant one requester, pulse its req_ready, latch address/store/owner, and enter AR (fill) or AW (store).
REQ-017 Arbitration SHALL be round-robin when both requesters are valid in the same cycle: the requester not granted last wins; after reset the D-cache wins first.
REQ-018 The latched address SHALL be line-aligned: low log2(LINE_BEATS*DATA_WIDTH/8) bits are cleared.
REQ-019 AR/AW fields SHALL be: len=LINE_BEATS-1, size=log2(DATA_WIDTH/8), burst=INCR (2'b01), lock=0, cache=0, prot=0; ID = 0 for the I-cache, 1 for the D-cache.
REQ-020 arvalid/awvalid SHALL assert in AR/AW and hold, with stable fields, until the ready handshake; then the FSM moves to RDATA/WDATA.
REQ-021 In RDATA: rready=1; each rvalid beat SHALL be forwarded the same cycle to the owner's rdata/rvalid; on the beat with rlast, owner done SHALL pulse next cycle and the FSM returns to IDLE.
REQ-022 In WDATA: wvalid=1, wdata=dc_wdata, wstrb=all ones; dc_wready=m_axi_wready; a 3-bit-minimum beat counter SHALL count handshakes; wlast=1 on beat LINE_BEATS-1; after the last beat the FSM enters BRESP.
REQ-023 In BRESP: bready=1; on bvalid, dc_done SHALL pulse next cycle and the FSM returns to IDLE; a nonzero bresp/rresp SHALL be ignored.
REQ-024 A request deasserted before its grant SHALL be dropped without side effects.
REQ-025 A new grant SHALL be possible in the first cycle after the done pulse, which gives one idle cycle between back-to-back transactions.

Reset
REQ-026 While reset is high: FSM SHALL enter IDLE; all valid/ready/done/strobe outputs SHALL be 0; the beat counter and round-robin pointer SHALL clear; data and address outputs SHALL be 0.
REQ-027 Reset mid-transaction SHALL abandon the burst immediately; no done pulse SHALL follow.

Configuration
REQ-028 When macro ARB_DCACHE_PRIORITY_EN is defined, the D-cache SHALL always win simultaneous requests (fixed priority); when undefined, the REQ-017 round-robin applies.

Verification
REQ-029 Single I-cache fill at 0x1008, 8 beats D0..D7 -> araddr=0x1000, arlen=7, arid=0; ic_rvalid 8 times carrying D0..D7; ic_done one cycle after rlast.
REQ-030 Simultaneous ic/dc requests twice in succession (macro undefined) -> dc granted first, ic granted second; dc_req_ready and ic_req_ready never both high.
REQ-031 Same stimulus with ARB_DCACHE_PRIORITY_EN defined -> dc granted both times while its request is held.
REQ-032 D-cache write-back to 0x2040 with wready toggled every cycle -> 8 W beats, wlast only on the 8th, dc_wready mirrors wready, dc_done one cycle after bvalid.
REQ-033 arready held low for 5 cycles -> arvalid and araddr stable for all 5 cycles, no rready-driven beats forwarded.
REQ-034 Reset asserted after beat 3 of a fill -> next cycle all outputs 0 and FSM in IDLE; no ic_done pulse; a following request proceeds normally.
